mdio_master: RTL and testbench

Clause 22 MDIO management-frame engine sitting directly downstream of the PHY configuration sequencer. It accepts one register access per valid/ready handshake, serialises the 64-bit frame (preamble, ST, OP, PHYAD, REGAD, TA, data) onto MDC/MDIO, and returns read data plus a no-response error flag. The MDIO pad is split into `mdio_i`, `mdio_o` and `mdio_oe`; the tristate buffer lives at the top level.

---
 rtl/mdio_master.sv | 192 +++++++++++++++++++
 tb/tb_mdio_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause 22 MDIO management-frame master.
// Takes one register access per valid/ready handshake, shifts the 64-bit
// frame out on mdc/mdio and returns read data plus a no-response flag.
// The pad tristate lives outside: this block only supplies mdio_o/mdio_oe.
module mdio_master #(
   parameter int PRESCALE = 128   // clk cycles per mdc period; even, >= 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wdata,
   input  logic [1:0]  op,
   input  logic        valid,
   output logic        ready,
   output logic [15:0] rdata,
   output logic        error
);

   localparam int PW = $clog2(PRESCALE);

   localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PC_RISE = PW'(PRESCALE / 2 - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam logic [5:0] BIT_LAST    = 6'd63;
   localparam logic [5:0] BIT_TA_HI   = 6'd46;
   localparam logic [5:0] BIT_TA_LO   = 6'd47;
   localparam logic [5:0] BIT_DATA    = 6'd48;

   // Request as captured at accept; later input changes are ignored.
   typedef struct packed {
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] wd;
   } req_t;

   req_t          req;
   logic [1:0]    state;
   logic [PW-1:0] pc;
   logic [5:0]    bit_cnt;
   logic [5:0]    bit_nxt;
   logic [63:0]   frame;
   logic [15:0]   shreg;
   logic          ta_q;

   logic accept;
   logic op_legal;
   logic is_read;
   logic pc_wrap;
   logic mdc_rise;
   logic last_bit;
   logic nxt_o;
   logic nxt_oe;

   assign accept   = (state == S_IDLE) && valid && ready;
   assign op_legal = (op == OP_WRITE) || (op == OP_READ);
   assign is_read  = (req.op == OP_READ);
   assign pc_wrap  = (state == S_SHIFT) && (pc == PC_LAST);
   assign mdc_rise = (state == S_SHIFT) && (pc == PC_RISE);
   assign last_bit = (bit_cnt == BIT_LAST);
   assign bit_nxt  = bit_cnt + 6'd1;

   // Frame image, MSB = first bit on the wire. The write TA/data tail is
   // overridden for reads, where the PHY owns bits 46..63.
   assign frame = {32'hFFFF_FFFF, 2'b01, req.op, req.phy, req.rg, 2'b10, req.wd};

   // Value and enable for the next bit, applied at the start of its low phase.
   always_comb begin
      nxt_o  = frame[BIT_LAST - bit_nxt];
      nxt_oe = 1'b1;
      if (is_read && (bit_nxt >= BIT_TA_HI)) begin
         nxt_o  = 1'b1;
         nxt_oe = 1'b0;
      end
   end

   // Sequencing: state, prescale counter and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  pc      <= '0;
                  bit_cnt <= '0;
                  state   <= op_legal ? S_SHIFT : S_DONE;
               end
            end
            S_SHIFT: begin
               if (pc == PC_LAST) begin
                  pc <= '0;
                  if (last_bit) state <= S_DONE;
                  else          bit_cnt <= bit_nxt;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Request capture on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req <= '0;
      end else if (accept) begin
         req.op  <= op;
         req.phy <= phy_addr;
         req.rg  <= reg_addr;
         req.wd  <= wdata;
      end
   end

   // Pad drive: mdc from the prescale phase, data/enable only at pc == 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdc     <= 1'b0;
         mdio_o  <= 1'b1;
         mdio_oe <= 1'b0;
      end else if (accept && op_legal) begin
         // Bit 0 is always a preamble one, driven for both reads and writes.
         mdc     <= 1'b0;
         mdio_o  <= 1'b1;
         mdio_oe <= 1'b1;
      end else if (state == S_SHIFT) begin
         if (mdc_rise) mdc <= 1'b1;
         if (pc_wrap) begin
            mdc <= 1'b0;
            if (last_bit) begin
               mdio_o  <= 1'b1;
               mdio_oe <= 1'b0;
            end else begin
               mdio_o  <= nxt_o;
               mdio_oe <= nxt_oe;
            end
         end
      end else begin
         mdc     <= 1'b0;
         mdio_o  <= 1'b1;
         mdio_oe <= 1'b0;
      end
   end

   // Read capture: sample on the clk edge where mdc goes high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ta_q  <= 1'b1;
         shreg <= '0;
      end else if (mdc_rise && is_read) begin
         if (bit_cnt == BIT_TA_LO) ta_q <= mdio_i;
         if (bit_cnt >= BIT_DATA)  shreg <= {shreg[14:0], mdio_i};
      end
   end

   // Handshake and sticky status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready <= 1'b1;
         rdata <= '0;
         error <= 1'b0;
      end else if (accept) begin
         ready <= 1'b0;
         error <= !op_legal;
      end else if (pc_wrap && last_bit) begin
         if (is_read) begin
            rdata <= shreg;
            // A missing PHY leaves the pull-up high during the TA low slot.
            error <= ta_q;
         end
      end else if ((state != S_IDLE) && (state != S_SHIFT)) begin
         ready <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master at PRESCALE = 4: a vector table of
// register accesses plus back-to-back, reset-mid-frame sequences.
module tb_mdio_master;

   localparam int P = 4;
   localparam int NCAP = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mdc;
   logic        mdio_i = 1'b1;
   logic        mdio_o;
   logic        mdio_oe;
   logic [4:0]  phy_addr = '0;
   logic [4:0]  reg_addr = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  op = '0;
   logic        valid = 1'b0;
   logic        ready;
   logic [15:0] rdata;
   logic        error;

   mdio_master #(.PRESCALE(P)) dut (
      .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
      .mdio_oe(mdio_oe), .phy_addr(phy_addr), .reg_addr(reg_addr),
      .wdata(wdata), .op(op), .valid(valid), .ready(ready), .rdata(rdata),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] wd;
      bit          phy_on;
      logic [15:0] phy_data;
      logic [63:0] exp_o;
      logic [63:0] exp_oe;
      int          exp_edges;
      int          exp_lat;
      logic [15:0] exp_rdata;
      logic        exp_err;
      logic        exp_err_acc;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Bus monitor and PHY model state (written only by the monitor).
   int   cyc = 0;
   int   cap_n = 0;
   int   low_run = 0;
   logic mdc_d = 1'b0;
   logic cap_o   [NCAP];
   logic cap_oe  [NCAP];
   int   rise_t  [NCAP];
   int   low_bef [NCAP];

   // PHY model configuration (written only by the stimulus).
   bit          phy_on = 1'b0;
   logic [15:0] phy_data = '0;
   int          phy_base = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record mdio at every mdc rise; PHY drives the next bit after each fall.
   always @(negedge clk) begin
      int k;
      if (mdc && !mdc_d) begin
         if (cap_n < NCAP) begin
            cap_o[cap_n]   = mdio_o;
            cap_oe[cap_n]  = mdio_oe;
            rise_t[cap_n]  = cyc;
            low_bef[cap_n] = low_run;
         end
         cap_n++;
      end
      if (mdc) low_run = 0;
      else     low_run++;
      if (!mdc && mdc_d) begin
         k = cap_n - phy_base;
         if (phy_on && k == 47)                mdio_i = 1'b0;
         else if (phy_on && k >= 48 && k <= 63) mdio_i = phy_data[63 - k];
         else                                  mdio_i = 1'b1;
      end
      mdc_d = mdc;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] frame_o(input int b);
      logic [63:0] f;
      for (int k = 0; k < 64; k++) f[63 - k] = cap_o[b + k];
      return f;
   endfunction

   function automatic logic [63:0] frame_oe(input int b);
      logic [63:0] f;
      for (int k = 0; k < 64; k++) f[63 - k] = cap_oe[b + k];
      return f;
   endfunction

   function automatic vec_t mk(input logic [1:0] o, input logic [4:0] p, input logic [4:0] r,
                               input logic [15:0] w, input bit on, input logic [15:0] pd,
                               input logic [63:0] eo, input logic [63:0] eoe, input int edges,
                               input int lat, input logic [15:0] erd, input logic ee,
                               input logic eacc);
      vec_t v;
      v.op = o; v.phy = p; v.rg = r; v.wd = w; v.phy_on = on; v.phy_data = pd;
      v.exp_o = eo; v.exp_oe = eoe; v.exp_edges = edges; v.exp_lat = lat;
      v.exp_rdata = erd; v.exp_err = ee; v.exp_err_acc = eacc;
      return v;
   endfunction

   // Wait at negedges until ready is high; returns edges waited (bounded).
   task automatic wait_ready(output int lat);
      lat = 0;
      while (!ready && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int base, lat;
      @(negedge clk);
      op = v.op; phy_addr = v.phy; reg_addr = v.rg; wdata = v.wd;
      phy_on = v.phy_on; phy_data = v.phy_data;
      base = cap_n; phy_base = cap_n;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      chk({name, " ready_drop"}, 64'(ready), 64'd0);
      chk({name, " error_at_accept"}, 64'(error), 64'(v.exp_err_acc));
      wait_ready(lat);
      chk({name, " latency"}, 64'(lat), 64'(v.exp_lat));
      chk({name, " mdc_edges"}, 64'(cap_n - base), 64'(v.exp_edges));
      if (v.exp_edges == 64 && cap_n - base == 64) begin
         chk({name, " frame_mdio_o"}, frame_o(base), v.exp_o);
         chk({name, " frame_mdio_oe"}, frame_oe(base), v.exp_oe);
      end
      chk({name, " rdata"}, 64'(rdata), 64'(v.exp_rdata));
      chk({name, " error"}, 64'(error), 64'(v.exp_err));
   endtask

   localparam logic [63:0] OE_W = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] OE_R = 64'hFFFF_FFFF_FFFC_0000;

   initial begin
      vec_t vecs [8];
      int base, lat;

      vecs[0] = mk(2'b01, 5'd0,  5'd20, 16'h0CE6, 1'b0, 16'h0000, 64'hFFFF_FFFF_5052_0CE6, OE_W, 64, 257, 16'h0000, 1'b0, 1'b0);
      vecs[1] = mk(2'b10, 5'd1,  5'd2,  16'h0000, 1'b1, 16'hABCD, 64'hFFFF_FFFF_608B_FFFF, OE_R, 64, 257, 16'hABCD, 1'b0, 1'b0);
      vecs[2] = mk(2'b10, 5'd3,  5'd1,  16'h0000, 1'b0, 16'h0000, 64'hFFFF_FFFF_6187_FFFF, OE_R, 64, 257, 16'hFFFF, 1'b1, 1'b0);
      vecs[3] = mk(2'b01, 5'd3,  5'd0,  16'h9140, 1'b0, 16'h0000, 64'hFFFF_FFFF_5182_9140, OE_W, 64, 257, 16'hFFFF, 1'b0, 1'b0);
      vecs[4] = mk(2'b11, 5'd3,  5'd0,  16'h1111, 1'b0, 16'h0000, 64'h0,                   64'h0, 0,  1,   16'hFFFF, 1'b1, 1'b1);
      vecs[5] = mk(2'b01, 5'd16, 5'd1,  16'h8001, 1'b0, 16'h0000, 64'hFFFF_FFFF_5806_8001, OE_W, 64, 257, 16'hFFFF, 1'b0, 1'b0);
      vecs[6] = mk(2'b00, 5'd5,  5'd5,  16'h2222, 1'b0, 16'h0000, 64'h0,                   64'h0, 0,  1,   16'hFFFF, 1'b1, 1'b1);
      vecs[7] = mk(2'b10, 5'd31, 5'd31, 16'h0000, 1'b1, 16'h1234, 64'hFFFF_FFFF_6FFF_FFFF, OE_R, 64, 257, 16'h1234, 1'b0, 1'b0);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst mdc", 64'(mdc), 64'd0);
      chk("rst mdio_o", 64'(mdio_o), 64'd1);
      chk("rst mdio_oe", 64'(mdio_oe), 64'd0);
      chk("rst ready", 64'(ready), 64'd1);
      chk("rst rdata", 64'(rdata), 64'd0);
      chk("rst error", 64'(error), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Sequencer-style back-to-back with valid held high
      @(negedge clk);
      op = 2'b01; phy_addr = 5'd0; reg_addr = 5'd20; wdata = 16'h0CE6;
      phy_on = 1'b0; base = cap_n; phy_base = cap_n;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_ready(lat);
      reg_addr = 5'd0; wdata = 16'h9140;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b ready_drop", 64'(ready), 64'd0);
      wait_ready(lat);
      repeat (300) @(negedge clk);
      chk("b2b edges", 64'(cap_n - base), 64'd128);
      chk("b2b ready_idle", 64'(ready), 64'd1);
      if (cap_n - base == 128) begin
         chk("b2b frame1", frame_o(base), 64'hFFFF_FFFF_5052_0CE6);
         chk("b2b frame2", frame_o(base + 64), 64'hFFFF_FFFF_5002_9140);
         chk("b2b oe1", frame_oe(base), OE_W);
         chk("b2b oe2", frame_oe(base + 64), OE_W);
         chk("b2b frame1 span", 64'(rise_t[base + 63] - rise_t[base]), 64'(63 * P));
         chk("b2b accept spacing", 64'(rise_t[base + 64] - rise_t[base]), 64'(64 * P + 2));
         chk("b2b mdc low gap", 64'(low_bef[base + 64]), 64'(P / 2 + 2));
      end

      // Async reset in the middle of a read frame
      @(negedge clk);
      op = 2'b10; phy_addr = 5'd2; reg_addr = 5'd3;
      phy_on = 1'b1; phy_data = 16'h0F0F; base = cap_n; phy_base = cap_n;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      lat = 0;
      while (cap_n - base < 21 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk("rmid reached bit20", 64'(cap_n - base), 64'd21);
      chk("rmid oe before", 64'(mdio_oe), 64'd1);
      rst = 1'b1;
      #1;
      chk("rmid mdc", 64'(mdc), 64'd0);
      chk("rmid mdio_oe", 64'(mdio_oe), 64'd0);
      chk("rmid mdio_o", 64'(mdio_o), 64'd1);
      chk("rmid ready", 64'(ready), 64'd1);
      chk("rmid rdata", 64'(rdata), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(mk(2'b10, 5'd2, 5'd3, 16'h0000, 1'b1, 16'h5A5A, 64'hFFFF_FFFF_610F_FFFF, OE_R,
                 64, 257, 16'h5A5A, 1'b0, 1'b0), "post_rst_read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
